// File: rtl/axi_mem_slave.sv
// AXI4 slave memory with independent read/write engines, FIXED/INCR/WRAP bursts and byte strobes.
// Define AXI_MEM_SLVERR_EN to flag out-of-range beats with SLVERR instead of wrapping the address.
module axi_mem_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_AW = $clog2(STRB_W);
    localparam int MEM_AW  = $clog2(MEM_BYTES);
    localparam int DEPTH   = MEM_BYTES / STRB_W;
    localparam int IDX_W   = MEM_AW - BYTE_AW;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Beat-to-beat address step; size is clamped to the bus width and WRAP folds inside its container.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [2:0]        eff_size;
        logic [ADDR_W-1:0] step, incr, container, base;
        eff_size  = (size > 3'(BYTE_AW)) ? 3'(BYTE_AW) : size;
        step      = ADDR_W'(1) << eff_size;
        incr      = (addr & ~(step - ADDR_W'(1))) + step;
        container = (ADDR_W'(len) + ADDR_W'(1)) << eff_size;
        base      = addr & ~(container - ADDR_W'(1));
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (incr == base + container) ? base : incr;
            default: next_addr = incr;
        endcase
    endfunction

`ifdef AXI_MEM_SLVERR_EN
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        out_of_range = |addr[ADDR_W-1:MEM_AW];
    endfunction
`endif

    w_state_t          w_state_reg, w_state_next;
    r_state_t          r_state_reg, r_state_next;
    logic              live_reg;
    logic [ID_W-1:0]   w_id_reg, r_id_reg;
    logic [ADDR_W-1:0] w_addr_reg, r_addr_reg, r_step_addr, rd_addr;
    logic [7:0]        w_len_reg, w_cnt_reg, r_len_reg, r_cnt_reg;
    logic [2:0]        w_size_reg, r_size_reg;
    logic [1:0]        w_burst_reg, r_burst_reg;
    logic              rlast_reg;
    logic              aw_hs, w_hs, ar_hs, r_hs, w_we, rd_en;
    logic [IDX_W-1:0]  w_idx, rd_idx;
    wire  [DATA_W-1:0] rd_data;

    always_comb begin
        w_state_next = w_state_reg;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                awready = live_reg;
                if (awvalid && live_reg) w_state_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (wlast || w_cnt_reg == w_len_reg)) w_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                arready = live_reg;
                if (arvalid && live_reg) r_state_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast_reg) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rready && rvalid;
    assign r_step_addr = next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
    assign rd_addr     = (r_state_reg == R_IDLE) ? araddr : r_step_addr;
    assign rd_en       = ar_hs || (r_hs && !rlast_reg);
    assign rd_idx      = rd_addr[MEM_AW-1:BYTE_AW];
    assign w_idx       = w_addr_reg[MEM_AW-1:BYTE_AW];
    assign bid         = w_id_reg;
    assign rid         = r_id_reg;
    assign rlast       = rlast_reg;

`ifdef AXI_MEM_SLVERR_EN
    logic w_err_reg, r_err_reg;
    assign w_we  = w_hs && !out_of_range(w_addr_reg);
    assign bresp = w_err_reg ? 2'b10 : 2'b00;
    assign rresp = r_err_reg ? 2'b10 : 2'b00;
    assign rdata = (rvalid && !r_err_reg) ? rd_data : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_err_reg <= 1'b0;
            r_err_reg <= 1'b0;
        end else begin
            if (aw_hs) w_err_reg <= 1'b0;
            else if (w_hs && out_of_range(w_addr_reg)) w_err_reg <= 1'b1;
            if (rd_en) r_err_reg <= out_of_range(rd_addr);
        end
    end
`else
    assign w_we  = w_hs;
    assign bresp = 2'b00;
    assign rresp = 2'b00;
    assign rdata = rvalid ? rd_data : '0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            r_state_reg <= R_IDLE;
            live_reg    <= 1'b0;
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_cnt_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= '0;
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            rlast_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
            live_reg    <= 1'b1;
            if (aw_hs) begin
                w_id_reg    <= awid;
                w_addr_reg  <= awaddr;
                w_len_reg   <= awlen;
                w_size_reg  <= awsize;
                w_burst_reg <= awburst;
                w_cnt_reg   <= '0;
            end else if (w_hs) begin
                w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
                w_cnt_reg  <= w_cnt_reg + 8'd1;
            end
            if (ar_hs) begin
                r_id_reg    <= arid;
                r_addr_reg  <= araddr;
                r_len_reg   <= arlen;
                r_size_reg  <= arsize;
                r_burst_reg <= arburst;
                r_cnt_reg   <= '0;
                rlast_reg   <= (arlen == 8'd0);
            end else if (r_hs && !rlast_reg) begin
                r_addr_reg <= r_step_addr;
                r_cnt_reg  <= r_cnt_reg + 8'd1;
                rlast_reg  <= (r_cnt_reg + 8'd1 == r_len_reg);
            end
        end
    end

    // One byte-wide RAM per lane so strobes map to plain write enables; reads are registered.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_reg;
        always_ff @(posedge aclk) begin
            if (w_we && wstrb[gi]) lane_mem[w_idx] <= wdata[gi*8 +: 8];
            if (rd_en) lane_rd_reg <= lane_mem[rd_idx];
        end
        assign rd_data[gi*8 +: 8] = lane_rd_reg;
    end
endmodule
